universal_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 19 +
 rtl/shift_step.sv | 34 +++
 rtl/universal_shifter.sv | 118 +++++++++++
 tb/tb_universal_shifter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the universal shifter: shift modes, directions and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LOGIC  = 2'b00,
    MODE_ARITH  = 2'b01,
    MODE_ROT    = 2'b10,
    MODE_SERIAL = 2'b11
  } mode_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift of a WIDTH-bit word in the selected mode/direction.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_t            i_mode,
  input  logic             i_dir,
  input  logic             i_serial,
  output logic [WIDTH-1:0] o_q
);

  logic w_fill;

  always_comb begin
    w_fill = 1'b0;
    case (i_mode)
      MODE_LOGIC:  w_fill = 1'b0;
      // Arithmetic left is identical to logical left: only a right shift replicates the sign.
      MODE_ARITH:  w_fill = (i_dir == DIR_RIGHT) ? i_q[WIDTH-1] : 1'b0;
      MODE_ROT:    w_fill = (i_dir == DIR_RIGHT) ? i_q[0] : i_q[WIDTH-1];
      MODE_SERIAL: w_fill = i_serial;
      default:     w_fill = 1'b0;
    endcase

    if (i_dir == DIR_RIGHT) begin
      o_q = {w_fill, i_q[WIDTH-1:1]};
    end else begin
      o_q = {i_q[WIDTH-2:0], w_fill};
    end
  end

endmodule

// File: rtl/universal_shifter.sv
// Parallel-load register with multi-cycle shifts (one position per clock) and busy/done status.
module universal_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] LP_WIDTH = AMT_W'(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt, w_step;
  logic [AMT_W-1:0] r_cnt, w_cnt_nxt, w_n;
  mode_t            r_mode, w_mode_nxt, w_mode_in;
  logic             r_dir, w_dir_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  assign w_mode_in = mode_t'(mode);

  // Rotations wrap modulo WIDTH; every other mode saturates at WIDTH steps.
  always_comb begin
    if (w_mode_in == MODE_ROT) begin
      w_n = amount % LP_WIDTH;
    end else begin
      w_n = (amount > LP_WIDTH) ? LP_WIDTH : amount;
    end
  end

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_q     (r_q),
    .i_mode  (r_mode),
    .i_dir   (r_dir),
    .i_serial(serial_in),
    .o_q     (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_dir_nxt   = r_dir;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (load) begin
          w_q_nxt = data_in;
        end else if (start) begin
          w_mode_nxt = w_mode_in;
          w_dir_nxt  = dir;
          w_cnt_nxt  = w_n;
          if (w_n != '0) begin
            w_state_nxt = SHIFT;
            w_busy_nxt  = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      SHIFT: begin
        w_q_nxt   = w_step;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == AMT_W'(1)) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_LOGIC;
      r_dir   <= DIR_RIGHT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_universal_shifter.sv
// Self-checking bench for universal_shifter (WIDTH=8, AMT_W=4) against an arithmetic reference model.
module tb_universal_shifter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] data_in;
  logic       start;
  logic [1:0] mode;
  logic       dir;
  logic [3:0] amount;
  logic       serial_in;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  cur_q;

  universal_shifter #(
    .WIDTH(8),
    .AMT_W(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .data_in  (data_in),
    .start    (start),
    .mode     (mode),
    .dir      (dir),
    .amount   (amount),
    .serial_in(serial_in),
    .q        (q),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_count(input int m, input int amt);
    if (m == 2) return amt % 8;
    return (amt > 8) ? 8 : amt;
  endfunction

  // Result of j shift positions applied to q0 as a whole-word operation.
  function automatic logic [7:0] ref_shift(input int q0, input int m, input int d, input int j, input int s);
    int v;
    int r;
    r = 0;
    case (m)
      0: r = d ? (q0 << j) : (q0 >> j);
      1: begin
        if (d) r = q0 << j;
        else begin
          v = (q0 >= 128) ? q0 - 256 : q0;
          r = v >>> j;
        end
      end
      2: r = d ? ((q0 << j) | (q0 >> (8 - j))) : ((q0 >> j) | (q0 << (8 - j)));
      default: begin
        if (d) r = (q0 << j) | (s ? ((1 << j) - 1) : 0);
        else   r = (q0 >> j) | (s ? (255 << (8 - j)) : 0);
      end
    endcase
    return 8'(r & 255);
  endfunction

  task automatic do_load(input logic [7:0] d);
    load    = 1'b1;
    data_in = d;
    tick();
    load  = 1'b0;
    cur_q = d;
    check_eq("load_q", q, d);
    check_eq("load_busy", busy, 0);
    check_eq("load_done", done, 0);
  endtask

  task automatic run_shift(input int m, input int d, input int amt, input int s, input bit mid_req);
    int n;
    int q0;
    q0        = cur_q;
    n         = eff_count(m, amt);
    mode      = 2'(m);
    dir       = 1'(d);
    amount    = 4'(amt);
    serial_in = 1'(s);
    start     = 1'b1;
    tick();
    start  = 1'b0;
    mode   = 2'($urandom_range(0, 3));
    dir    = 1'($urandom_range(0, 1));
    amount = 4'($urandom_range(0, 15));
    check_eq("start_q", q, q0);
    check_eq("start_busy", busy, (n > 0) ? 1 : 0);
    check_eq("start_done", done, (n == 0) ? 1 : 0);
    for (int j = 1; j <= n; j++) begin
      if (mid_req && j == 1) begin
        load    = 1'b1;
        start   = 1'b1;
        data_in = 8'($urandom_range(0, 255));
      end
      tick();
      load  = 1'b0;
      start = 1'b0;
      check_eq("step_q", q, ref_shift(q0, m, d, j, s));
      check_eq("step_busy", busy, (j < n) ? 1 : 0);
      check_eq("step_done", done, (j == n) ? 1 : 0);
    end
    cur_q = ref_shift(q0, m, d, n, s);
    tick();
    check_eq("after_done", done, 0);
    check_eq("after_busy", busy, 0);
    check_eq("after_q", q, cur_q);
  endtask

  initial begin
    reset_n   = 1'b0;
    load      = 1'b0;
    data_in   = '0;
    start     = 1'b0;
    mode      = '0;
    dir       = 1'b0;
    amount    = '0;
    serial_in = 1'b0;
    tick();
    tick();
    check_eq("rst_q", q, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    reset_n = 1'b1;
    tick();

    // Reset mid-shift aborts without a done pulse.
    do_load(8'h96);
    mode = 2'b00; dir = 1'b0; amount = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("midrst_q", q, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    tick();
    check_eq("postrst_done", done, 0);
    check_eq("postrst_busy", busy, 0);
    do_load(8'h5A);

    // Directed cases with hand-derived results.
    do_load(8'h96); run_shift(1, 0, 3, 0, 0);
    check_eq("asr3", q, 8'hF2);
    do_load(8'h96); run_shift(0, 0, 3, 0, 0);
    check_eq("lsr3", q, 8'h12);
    do_load(8'h96); run_shift(2, 1, 3, 0, 0);
    check_eq("rol3", q, 8'hB4);
    do_load(8'h96); run_shift(2, 1, 9, 0, 0);
    check_eq("rol9", q, 8'h2D);
    do_load(8'h00); run_shift(3, 0, 4, 1, 0);
    check_eq("ser4", q, 8'hF0);
    do_load(8'hFF); run_shift(0, 1, 12, 0, 0);
    check_eq("lsl_sat", q, 8'h00);
    do_load(8'h80); run_shift(1, 0, 15, 0, 0);
    check_eq("asr_sat", q, 8'hFF);
    do_load(8'h6C); run_shift(0, 0, 0, 0, 0);
    check_eq("amt0", q, 8'h6C);
    do_load(8'h6C); run_shift(2, 0, 8, 0, 0);
    check_eq("rot8", q, 8'h6C);

    // Simultaneous load and start: load wins, start dropped.
    load = 1'b1; start = 1'b1; data_in = 8'h3C; mode = 2'b00; dir = 1'b0; amount = 4'd3;
    tick();
    load = 1'b0; start = 1'b0;
    check_eq("ls_q", q, 8'h3C);
    check_eq("ls_busy", busy, 0);
    check_eq("ls_done", done, 0);
    tick();
    check_eq("ls_q2", q, 8'h3C);
    check_eq("ls_busy2", busy, 0);
    cur_q = 8'h3C;

    // Requests during SHIFT are ignored.
    run_shift(0, 1, 5, 0, 1);
    run_shift(3, 1, 6, 1, 1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) do_load(8'($urandom_range(0, 255)));
      run_shift(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
